// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame defaults and baud divisor width.
package uart_pkg;

  localparam int unsigned DbitDefault   = 8;
  localparam int unsigned SbTickDefault = 16;
  localparam int unsigned DivW          = 10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick every final_value+1 clocks (16x oversample).
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [DivW-1:0] final_value,
  output logic            tick
);

  logic [DivW-1:0] cnt_q;

  // Compare with >= so that lowering the divisor below the running count reloads at once.
  assign tick = (cnt_q >= final_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DivW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DbitDefault,
  parameter int unsigned SB_TICK = SbTickDefault,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DivW-1:0] final_value,
  input  logic            rx,
  input  logic            rd_en,
  output logic [7:0]      data_out,
  output logic            empty,
  output logic            full,
  output logic            frame_err,
  output logic            overrun
);

  localparam int unsigned Depth     = 2 ** ADDR_W;
  localparam logic [2:0]  NLast     = 3'(DBIT - 1);
  localparam logic [3:0]  SMid      = 4'd7;
  localparam logic [3:0]  SBitLast  = 4'd15;
  localparam logic [3:0]  SStopLast = 4'(SB_TICK - 1);
  localparam logic [ADDR_W:0] PtrOne = 1;

  // Synchroniser: rx is asynchronous to clk.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  logic tick;

  uart_baud_gen u_baud_gen (
    .clk         (clk),
    .reset       (reset),
    .final_value (final_value),
    .tick        (tick)
  );

  rx_state_e   state_q;
  logic [3:0]  s_cnt_q;
  logic [2:0]  n_q;
  logic [7:0]  shift_q;
  logic        frame_err_q;
  logic        overrun_q;

  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic [7:0]      mem_q [Depth];

  logic stop_done;
  logic push;
  logic pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign data_out = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign pop      = rd_en && !empty;

  // A full FIFO still accepts the byte when a pop frees the head slot in the same cycle.
  assign stop_done = (state_q == StStop) && tick && (s_cnt_q == SStopLast);
  assign push      = stop_done && rx_s && (!full || pop);

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      s_cnt_q     <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            s_cnt_q <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (s_cnt_q == SMid) begin
              if (!rx_s) begin
                state_q <= StData;
                s_cnt_q <= '0;
                n_q     <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (s_cnt_q == SBitLast) begin
              shift_q <= {rx_s, shift_q[7:1]};
              s_cnt_q <= '0;
              if (n_q == NLast) begin
                state_q <= StStop;
              end else begin
                n_q <= n_q + 3'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (s_cnt_q == SStopLast) begin
              state_q     <= StIdle;
              frame_err_q <= !rx_s;
              overrun_q   <= rx_s && full && !pop;
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= shift_q;
        wr_ptr_q                    <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, expected bytes queued and checked on pop.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [9:0] final_value;
  logic       rx;
  logic       rd_en;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  logic [7:0] exp_q [$];

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .final_value (final_value),
    .rx          (rx),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; rd_at selects a cycle index for a one-cycle pop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks,
                            input int rd_at, output logic empty_a, output logic empty_b,
                            output logic [7:0] popped);
    logic [9:0] frame;
    frame   = {stop_bit, b, 1'b0};
    empty_a = 1'b0;
    empty_b = 1'b0;
    popped  = 8'h00;
    for (int k = 0; k < 10 * bit_clks; k++) begin
      if (k == 154) empty_a = empty;
      if (k == 155) empty_b = empty;
      if (k == rd_at) popped = data_out;
      rx    = frame[k / bit_clks];
      rd_en = (k == rd_at);
      @(negedge clk);
    end
    rx    = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic expect_push);
    logic a, e;
    logic [7:0] p;
    send_frame(b, 1'b1, 16, -1, a, e, p);
    if (expect_push) exp_q.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    check({tag, "_nonempty"}, {31'd0, empty}, 32'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_data(input string tag, input int budget);
    int n = 0;
    while (empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_arrived"}, {31'd0, empty}, 32'd0);
  endtask

  initial begin
    logic       ea, eb;
    logic [7:0] popped;
    int         fe0, ov0;

    // 1: reset and idle line
    reset       = 1'b1;
    rx          = 1'b1;
    rd_en       = 1'b0;
    final_value = 10'd0;
    @(negedge clk);
    reset  = 1'b0;
    fe_cnt = 0;
    ov_cnt = 0;
    repeat (20) @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_pulses", fe_cnt + ov_cnt, 0);

    // 2: single frame, latency of one clock after the stop sample
    send_frame(8'hE7, 1'b1, 16, -1, ea, eb, popped);
    exp_q.push_back(8'hE7);
    check("lat_before", {31'd0, ea}, 32'd1);
    check("lat_after", {31'd0, eb}, 32'd0);
    pop_check("e7");
    check("e7_drained", {31'd0, empty}, 32'd1);

    // 3: back-to-back frames, then an ignored pop on empty
    send(8'h86, 1'b1);
    send(8'hF6, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h80, 1'b1);
    send(8'hE4, 1'b1);
    send(8'hE6, 1'b1);
    for (int i = 0; i < 6; i++) pop_check("b2b");
    check("b2b_empty", {31'd0, empty}, 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_empty_ignored", {31'd0, empty}, 32'd1);
    send(8'h3C, 1'b1);
    pop_check("after_bad_pop");

    // 4: framing error, then a good frame
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 16, -1, ea, eb, popped);
    check("ferr_pulse", fe_cnt - fe0, 1);
    check("ferr_no_push", {31'd0, empty}, 32'd1);
    send(8'hA5, 1'b1);
    pop_check("a5");

    // 5a: fill, overflow on the 17th frame
    for (int i = 0; i < 16; i++) send(8'(i * 13 + 7), 1'b1);
    check("full_16", {31'd0, full}, 32'd1);
    ov0 = ov_cnt;
    send(8'hC3, 1'b0);
    check("overrun_pulse", ov_cnt - ov0, 1);
    check("overrun_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("ovr_drain");
    check("ovr_drained", {31'd0, empty}, 32'd1);

    // 5b: refill, pop exactly on the 17th push cycle
    for (int i = 0; i < 16; i++) send(8'(i * 29 + 3), 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h4B, 1'b1, 16, 154, ea, eb, popped);
    check("simul_pop_head", {24'd0, popped}, {24'd0, exp_q.pop_front()});
    exp_q.push_back(8'h4B);
    check("simul_no_overrun", ov_cnt - ov0, 0);
    check("simul_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("simul_drain");

    // 6a: short low glitch on rx
    fe0   = fe_cnt;
    rx    = 1'b0;
    repeat (4) @(negedge clk);
    rx    = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_push", {31'd0, empty}, 32'd1);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // 6b: reset in the middle of DATA flushes the FIFO
    send(8'h96, 1'b1);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_full", {31'd0, full}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'h00);
    repeat (40) @(negedge clk);
    check("midrst_quiet", {31'd0, empty}, 32'd1);
    send(8'h5A, 1'b1);
    pop_check("after_rst");

    // 6c: non-zero divisor
    final_value = 10'd40;
    send_frame(8'hE7, 1'b1, 16 * 41, -1, ea, eb, popped);
    exp_q.push_back(8'hE7);
    wait_data("slow", 2000);
    pop_check("slow");

    check("never_both_pulses", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
